bsg_nonsynth_dramsim3_req_buffer: RTL and testbench
===================================================

// Module: bsg_nonsynth_dramsim3_req_buffer
// PURPOSE
// - Per-channel request buffer feeding one channel of the dramsim3 memory model.
// - Accepts combined read/write requests (addr + write data + mask) on a ready/valid port.
// - Queues them in order and presents the head to the model's v/write_not_read/ch_addr/data_v port.
// - Bounds outstanding reads with a credit counter that is returned by the model's read-done valid.
// PARAMETERS
// - channel_addr_width_p, "inv", channel byte-address width; matches the memory model.
// - data_width_p,         "inv", data beat width; must be a multiple of 8.
// - els_p,                4,     queue depth; power of 2, >= 2.
// - max_reads_p,          8,     maximum outstanding reads, >= 1.
// - mask_width_lp,        data_width_p>>3, byte mask width.
// - rd_cnt_width_lp,      `BSG_SAFE_CLOG2(max_reads_p+1), width of the read counter.
// PORTS
// - clk_i                input  1                     clock
// - reset_i              input  1                     synchronous, active-high reset
// - v_i                  input  1                     upstream request valid
// - write_not_read_i     input  1                     1 = write, 0 = read
// - ch_addr_i            input  channel_addr_width_p  channel byte address
// - data_i               input  data_width_p          write data (ignored for reads)
// - mask_i               input  mask_width_lp         write byte mask (ignored for reads)
// - ready_o              output 1                     buffer can accept a request
// - v_o                  output 1                     head request valid to memory model
// - write_not_read_o     output 1                     head type
// - ch_addr_o            output channel_addr_width_p  head address
// - data_v_o             output 1                     head write data valid
// - data_o               output data_width_p          head write data
// - mask_o               output mask_width_lp         head write mask
// - yumi_i               input  1                     model accepted the head (request yumi)
// - read_done_i          input  1                     model returned one read beat (credit return)
// - outstanding_reads_o  output rd_cnt_width_lp       reads issued but not yet returned
// - empty_o              output 1                     queue empty and no outstanding reads
// - full_stall_o         output 32                    stats: cycles with v_i & ~ready_o
// - credit_stall_o       output 32                    stats: cycles with a read head blocked by credit
// BEHAVIOUR
// - Reset: queue empty, ready_o=1, v_o=0, data_v_o=0, outstanding_reads_o=0, empty_o=1, stats=0.
//   Reset mid-operation discards all queued entries and zeroes the credit count.
// - Enqueue: v_i & ready_o. ready_o = ~full; a dequeue in the same cycle does not free the slot.
// - No bypass: an entry appears at the head in the cycle after it is enqueued, at the earliest.
// - Head gating: v_o = ~queue_empty & (head_write | outstanding_reads_o < max_reads_p).
// - data_v_o = v_o & head_write. write_not_read_o, ch_addr_o, data_o and mask_o show the head whenever the queue is non-empty.
// - Dequeue on yumi_i. yumi_i without v_o is illegal: assertion error, no state change.
// - Credit counter: +1 on (yumi_i & ~head_write), -1 on read_done_i; both in one cycle leaves it unchanged.
//   read_done_i at count 0 is illegal: assertion error, count stays 0.
// - Writes never consume credit. A read head blocked by credit also blocks the writes behind it (strict order).
// - Pointers wrap modulo els_p; full/empty are distinguished by an extra wrap bit.
// - empty_o = queue_empty & (outstanding_reads_o == 0).
// CONFIGURATION
// - BSG_DRAMSIM3_REQ_BUFFER_STATS_EN defined: full_stall_o and credit_stall_o count the qualifying cycles.
//   Counters saturate at 32'hFFFF_FFFF, clear on reset, and ignore the reset cycle.
// - Not defined: both outputs are tied to 32'b0 and the counter flops are not instantiated.
// TESTING
// - Reset, 1 write (addr 0x40, data 0xA5.., mask all-1s): v_o=data_v_o=1 next cycle; yumi_i -> empty_o=1.
// - max_reads_p=2, 3 reads enqueued, yumi_i held: 2 issued, v_o=0 with count=2;
//   one read_done_i -> third read issues.
// - els_p=4, 5 back-to-back v_i with no yumi_i: ready_o=0 after 4 accepted; the 5th holds until a dequeue.
// - Simultaneous read yumi_i and read_done_i at count=1: count stays 1.
// - Reads R(0x0) and R(0x40) then W(0x80) with max_reads_p=1: W issues only after the second read's credit returns.
// - STATS_EN: 10 cycles of v_i with the queue full -> full_stall_o=10; without the macro, full_stall_o=0.
// - Reset asserted with 3 entries queued and 1 read outstanding -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bsg_nonsynth_dramsim3_req_buffer.sv
// In-order request queue for one dramsim3 channel, with read-credit gating of the head.
// Define BSG_DRAMSIM3_REQ_BUFFER_STATS_EN to build the full/credit stall counters.
module bsg_nonsynth_dramsim3_req_buffer
  #(parameter int channel_addr_width_p = 32
  , parameter int data_width_p = 64
  , parameter int els_p = 4
  , parameter int max_reads_p = 8
  , localparam int mask_width_lp = data_width_p >> 3
  , localparam int rd_cnt_width_lp = ((max_reads_p + 1) > 1) ? $clog2(max_reads_p + 1) : 1
  )
  (input  logic                            clk_i
  , input  logic                            reset_i

  , input  logic                            v_i
  , input  logic                            write_not_read_i
  , input  logic [channel_addr_width_p-1:0] ch_addr_i
  , input  logic [data_width_p-1:0]         data_i
  , input  logic [mask_width_lp-1:0]        mask_i
  , output logic                            ready_o

  , output logic                            v_o
  , output logic                            write_not_read_o
  , output logic [channel_addr_width_p-1:0] ch_addr_o
  , output logic                            data_v_o
  , output logic [data_width_p-1:0]         data_o
  , output logic [mask_width_lp-1:0]        mask_o
  , input  logic                            yumi_i

  , input  logic                            read_done_i
  , output logic [rd_cnt_width_lp-1:0]      outstanding_reads_o
  , output logic                            empty_o

  , output logic [31:0]                     full_stall_o
  , output logic [31:0]                     credit_stall_o
  );

  localparam int lg_els_lp = $clog2(els_p);
  localparam logic [rd_cnt_width_lp-1:0] max_reads_lp = rd_cnt_width_lp'(max_reads_p);

  typedef struct packed {
    logic                            write_not_read;
    logic [channel_addr_width_p-1:0] addr;
    logic [data_width_p-1:0]         data;
    logic [mask_width_lp-1:0]        mask;
  } entry_s;

  entry_s mem [els_p];
  entry_s head;
  entry_s incoming;

  logic [lg_els_lp:0] wptr, rptr;
  logic queue_empty, queue_full;
  logic enq, deq;
  logic credit_ok;
  logic rd_inc, rd_dec;
  logic [rd_cnt_width_lp-1:0] rd_cnt;

  // Extra MSB on each pointer tells a full queue from an empty one.
  assign queue_empty = (wptr == rptr);
  assign queue_full  = (wptr[lg_els_lp] != rptr[lg_els_lp])
                    && (wptr[lg_els_lp-1:0] == rptr[lg_els_lp-1:0]);

  assign head = mem[rptr[lg_els_lp-1:0]];

  assign incoming.write_not_read = write_not_read_i;
  assign incoming.addr           = ch_addr_i;
  assign incoming.data           = data_i;
  assign incoming.mask           = mask_i;

  // Full is judged on registered state only, so a same-cycle dequeue never frees a slot.
  assign ready_o = ~queue_full;
  assign enq     = v_i & ~queue_full;

  assign credit_ok = (rd_cnt < max_reads_lp);
  assign v_o       = ~queue_empty & (head.write_not_read | credit_ok);
  assign deq       = yumi_i & v_o;

  assign write_not_read_o = head.write_not_read;
  assign ch_addr_o        = head.addr;
  assign data_o           = head.data;
  assign mask_o           = head.mask;
  assign data_v_o         = v_o & head.write_not_read;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr[lg_els_lp-1:0]] <= incoming;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
    end
    else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
    end
  end

  // A spurious read_done at zero is dropped so the count cannot underflow.
  assign rd_inc = deq & ~head.write_not_read;
  assign rd_dec = read_done_i & (rd_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_cnt <= '0;
    end
    else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  assign outstanding_reads_o = rd_cnt;
  assign empty_o             = queue_empty & (rd_cnt == '0);

`ifdef BSG_DRAMSIM3_REQ_BUFFER_STATS_EN
  logic [31:0] full_stall_r, credit_stall_r;
  logic        full_stall_hit, credit_stall_hit;

  assign full_stall_hit   = v_i & ~ready_o;
  assign credit_stall_hit = ~queue_empty & ~head.write_not_read & ~credit_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_stall_r   <= '0;
      credit_stall_r <= '0;
    end
    else begin
      if (full_stall_hit && (full_stall_r != 32'hFFFF_FFFF))
        full_stall_r <= full_stall_r + 32'd1;
      if (credit_stall_hit && (credit_stall_r != 32'hFFFF_FFFF))
        credit_stall_r <= credit_stall_r + 32'd1;
    end
  end

  assign full_stall_o   = full_stall_r;
  assign credit_stall_o = credit_stall_r;
`else
  assign full_stall_o   = 32'b0;
  assign credit_stall_o = 32'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!yumi_i || v_o)
        else $error("bsg_nonsynth_dramsim3_req_buffer: yumi_i without v_o");
      assert (!read_done_i || (rd_cnt != '0))
        else $error("bsg_nonsynth_dramsim3_req_buffer: read_done_i with no outstanding reads");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_req_buffer.sv
// Bench for bsg_nonsynth_dramsim3_req_buffer: directed scenarios plus random traffic vs a queue model.
module tb_bsg_nonsynth_dramsim3_req_buffer;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int ELS  = 4;
  localparam int MAXR = 2;
  localparam int MW   = DW / 8;
  localparam int CW   = 2;

`ifdef BSG_DRAMSIM3_REQ_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          v_i, write_not_read_i, ready_o;
  logic [AW-1:0] ch_addr_i, ch_addr_o;
  logic [DW-1:0] data_i, data_o;
  logic [MW-1:0] mask_i, mask_o;
  logic          v_o, write_not_read_o, data_v_o, yumi_i, read_done_i, empty_o;
  logic [CW-1:0] outstanding_reads_o;
  logic [31:0]   full_stall_o, credit_stall_o;

  bsg_nonsynth_dramsim3_req_buffer
    #(.channel_addr_width_p(AW), .data_width_p(DW), .els_p(ELS), .max_reads_p(MAXR))
  dut
    (.clk_i(clk), .reset_i(reset_i)
    ,.v_i(v_i), .write_not_read_i(write_not_read_i), .ch_addr_i(ch_addr_i)
    ,.data_i(data_i), .mask_i(mask_i), .ready_o(ready_o)
    ,.v_o(v_o), .write_not_read_o(write_not_read_o), .ch_addr_o(ch_addr_o)
    ,.data_v_o(data_v_o), .data_o(data_o), .mask_o(mask_o), .yumi_i(yumi_i)
    ,.read_done_i(read_done_i), .outstanding_reads_o(outstanding_reads_o), .empty_o(empty_o)
    ,.full_stall_o(full_stall_o), .credit_stall_o(credit_stall_o));

  typedef struct {
    bit          wnr;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
    bit [MW-1:0] mask;
  } req_t;

  req_t    mq[$];
  int      m_cnt;
  longint  m_full_stall, m_credit_stall;
  int      n_assert = 0;
  int      n_fail   = 0;

  function automatic bit m_v();
    return (mq.size() > 0) && (mq[0].wnr || (m_cnt < MAXR));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    chk("ready_o", ready_o, mq.size() < ELS);
    chk("v_o", v_o, m_v());
    chk("data_v_o", data_v_o, m_v() && mq[0].wnr);
    if (mq.size() > 0) begin
      chk("write_not_read_o", write_not_read_o, mq[0].wnr);
      chk("ch_addr_o", ch_addr_o, mq[0].addr);
      chk("data_o", data_o, mq[0].data);
      chk("mask_o", mask_o, mq[0].mask);
    end
    chk("outstanding_reads_o", outstanding_reads_o, m_cnt);
    chk("empty_o", empty_o, (mq.size() == 0) && (m_cnt == 0));
    chk("full_stall_o", full_stall_o, STATS ? m_full_stall : 0);
    chk("credit_stall_o", credit_stall_o, STATS ? m_credit_stall : 0);
  endtask

  // Check outputs mid-cycle, then advance the model by one clock using the held inputs.
  task automatic cycle();
    req_t r;
    @(negedge clk);
    check_all();
    if (reset_i) begin
      mq.delete();
      m_cnt = 0;
      m_full_stall = 0;
      m_credit_stall = 0;
    end
    else begin
      if (v_i && (mq.size() == ELS)) m_full_stall++;
      if ((mq.size() > 0) && !mq[0].wnr && (m_cnt >= MAXR)) m_credit_stall++;
      if (yumi_i && !mq[0].wnr) m_cnt++;
      if (read_done_i) m_cnt--;
      if (yumi_i) void'(mq.pop_front());
      if (v_i && (mq.size() + (yumi_i ? 1 : 0) < ELS)) begin
        r.wnr = write_not_read_i; r.addr = ch_addr_i; r.data = data_i; r.mask = mask_i;
        mq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input bit wnr, input bit [AW-1:0] a, input bit [DW-1:0] d,
                      input bit [MW-1:0] m, input bit yreq, input bit rreq);
    reset_i          = 1'b0;
    v_i              = v;
    write_not_read_i = wnr;
    ch_addr_i        = a;
    data_i           = d;
    mask_i           = m;
    yumi_i           = yreq && m_v();
    read_done_i      = rreq && (m_cnt > 0);
    cycle();
  endtask

  task automatic idle(input bit yreq, input bit rreq);
    step(1'b0, 1'b0, '0, '0, '0, yreq, rreq);
  endtask

  task automatic do_reset(input bit v);
    reset_i = 1'b1; v_i = v; yumi_i = 1'b0; read_done_i = 1'b0;
    cycle();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 0; write_not_read_i = 0; ch_addr_i = '0; data_i = '0; mask_i = '0;
    yumi_i = 0; read_done_i = 0;
    m_cnt = 0; m_full_stall = 0; m_credit_stall = 0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // reset values
    chk("rst_ready", ready_o, 1); chk("rst_v", v_o, 0); chk("rst_data_v", data_v_o, 0);
    chk("rst_cnt", outstanding_reads_o, 0); chk("rst_empty", empty_o, 1);

    // single write: not visible in the enqueue cycle, visible the next
    step(1, 1, 16'h0040, 32'hA5A5_A5A5, 4'hF, 0, 0);
    chk("wr_v", v_o, 1); chk("wr_data_v", data_v_o, 1); chk("wr_addr", ch_addr_o, 16'h0040);
    idle(1, 0);
    chk("wr_empty", empty_o, 1);

    // three reads with yumi held and two credits
    step(1, 0, 16'h0100, 32'h1, 4'h0, 1, 0);
    step(1, 0, 16'h0140, 32'h2, 4'h0, 1, 0);
    step(1, 0, 16'h0180, 32'h3, 4'h0, 1, 0);
    chk("cred_blk_v", v_o, 0); chk("cred_blk_cnt", outstanding_reads_o, 2);
    idle(1, 0);
    idle(1, 1);
    chk("cred_ret_v", v_o, 1);
    idle(1, 0);
    chk("cred_third_cnt", outstanding_reads_o, 2);
    idle(0, 1); idle(0, 1);
    chk("cred_drain_empty", empty_o, 1);

    // fill, then ten cycles of v_i against a full queue
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1, 1, 16'(i * 'h10), 32'(i + 'h50), 4'h3, 0, 0);
    chk("full_ready", ready_o, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 16'h0ee0, 32'hEEEE, 4'hC, 0, 0);
    chk("full_stall10", full_stall_o, STATS ? 10 : 0);
    step(1, 1, 16'h0ee0, 32'hEEEE, 4'hC, 1, 0);
    chk("full_after_deq", ready_o, 1);
    step(1, 1, 16'h0ee0, 32'hEEEE, 4'hC, 0, 0);
    for (int i = 0; i < 5; i++) idle(1, 0);
    chk("full_drained", empty_o, 1);

    // simultaneous read issue and read return at count 1
    do_reset(1'b0);
    step(1, 0, 16'h0200, 0, 0, 0, 0);
    step(1, 0, 16'h0240, 0, 0, 1, 0);
    chk("sim_cnt1", outstanding_reads_o, 1);
    idle(1, 1);
    chk("sim_cnt_hold", outstanding_reads_o, 1);
    idle(0, 1);

    // strict ordering: write waits behind a credit-blocked read
    do_reset(1'b0);
    step(1, 0, 16'h0000, 0, 0, 0, 0);
    step(1, 0, 16'h0040, 0, 0, 0, 0);
    step(1, 0, 16'h0080, 0, 0, 0, 0);
    step(1, 1, 16'h00c0, 32'h77, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) idle(1, 0);
    chk("ord_blk_v", v_o, 0); chk("ord_blk_wnr", write_not_read_o, 0);
    chk("ord_cstall", credit_stall_o, STATS ? 2 : 0);
    idle(1, 1);
    idle(1, 0);
    chk("ord_w_head", data_v_o, 1); chk("ord_w_addr", ch_addr_o, 16'h00c0);
    idle(1, 0);
    idle(0, 1); idle(0, 1);

    // reset with entries queued and a read outstanding
    step(1, 0, 16'h0300, 0, 0, 0, 0);
    step(1, 1, 16'h0310, 32'h9, 4'h1, 1, 0);
    step(1, 1, 16'h0320, 32'hA, 4'h2, 0, 0);
    step(1, 1, 16'h0330, 32'hB, 4'h4, 0, 0);
    do_reset(1'b1);
    chk("mid_rst_ready", ready_o, 1); chk("mid_rst_v", v_o, 0);
    chk("mid_rst_cnt", outstanding_reads_o, 0); chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_fstall", full_stall_o, 0); chk("mid_rst_cstall", credit_stall_o, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1));
      else step($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom), $urandom,
                4'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
    end
    idle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
